// File: rtl/backend_types.sv
// Shared backend type package.
// Holds the instruction-queue entry layout plus fetch-side state and constants.
package backend_types;

  // One instruction-queue entry: the fetch PC and the instruction word fetched from it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iqueue_t;

  // Fetch FSM states:
  //   REQ   - ready to issue a request for pc_r
  //   WAIT  - one request outstanding
  //   HOLD  - response captured in hold_r, waiting for queue space
  //   DRAIN - redirected while a request was in flight; swallow its response
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [3:0] IMEM_RMASK_WORD = 4'hF;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end.
// Walks a PC from RESET_VEC, fetches one 32-bit word per imem request and pushes {pc, inst}
// into the instruction queue. Handles queue backpressure and backend redirects.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_addr/imem_rmask          request address and read mask (4'hF for one cycle per request)
//   imem_rdata/imem_resp          response word and one-cycle response pulse
//   iq_wen/iq_wdata/iq_full       instruction queue push, entry and full flag
//   redirect_valid/redirect_pc    backend flush and new fetch PC
module fetch_unit
  import backend_types::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h6000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        iq_wen,
  output iqueue_t     iq_wdata,
  input  logic        iq_full,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_t state_r, state_d;
  logic [31:0]  pc_r, pc_d;
  logic [31:0]  hold_r, hold_d;

  logic [31:0]  w_pc_inc;
  logic [31:0]  w_redirect_pc;

  assign w_pc_inc      = pc_r + 32'd4;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= REQ;
      pc_r    <= RESET_VEC;
      hold_r  <= '0;
    end else begin
      state_r <= state_d;
      pc_r    <= pc_d;
      hold_r  <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_r;
    pc_d       = pc_r;
    hold_d     = hold_r;
    imem_addr  = '0;
    imem_rmask = '0;
    iq_wen     = 1'b0;
    iq_wdata   = '0;

    if (!rst) begin
      unique case (state_r)
        REQ: begin
          if (redirect_valid) begin
            pc_d = w_redirect_pc;
          end else if (!iq_full) begin
            imem_addr  = pc_r;
            imem_rmask = IMEM_RMASK_WORD;
            state_d    = WAIT;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            pc_d = w_redirect_pc;
            // A response arriving with the redirect is simply dropped; otherwise it is
            // still coming and must be drained before the next request.
            state_d = imem_resp ? REQ : DRAIN;
          end else if (imem_resp) begin
            if (!iq_full) begin
              iq_wen        = 1'b1;
              iq_wdata.pc   = pc_r;
              iq_wdata.inst = imem_rdata;
              pc_d          = w_pc_inc;
              // Issue the next request in the same cycle to sustain one word per cycle.
              imem_addr     = w_pc_inc;
              imem_rmask    = IMEM_RMASK_WORD;
            end else begin
              hold_d  = imem_rdata;
              state_d = HOLD;
            end
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            pc_d    = w_redirect_pc;
            state_d = REQ;
          end else if (!iq_full) begin
            iq_wen        = 1'b1;
            iq_wdata.pc   = pc_r;
            iq_wdata.inst = hold_r;
            pc_d          = w_pc_inc;
            state_d       = REQ;
          end
        end

        DRAIN: begin
          if (redirect_valid) pc_d = w_redirect_pc;
          if (imem_resp) state_d = REQ;
        end

        default: state_d = REQ;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    iq_wen |-> !iq_full);

  a_rmask_legal: assert property (@(posedge clk) disable iff (rst)
    (imem_rmask == 4'h0) || (imem_rmask == IMEM_RMASK_WORD));

  // A new request may only leave REQ, or WAIT in the cycle the previous one completes.
  a_single_outstanding: assert property (@(posedge clk) disable iff (rst)
    (imem_rmask != 4'h0) |-> ((state_r == REQ) || (state_r == WAIT && imem_resp)));

  a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
    imem_resp |-> ((state_r == WAIT) || (state_r == DRAIN)));

endmodule
